// File: rtl/mem_stage.sv
`default_nettype none

// ============================================================================
//  Module      : mem_stage
//  Description : Memory pipeline stage. Splits loads and stores into single
//                byte accesses to a byte-wide arbiter port, assembles load
//                data little-endian, extends it by instruction type and
//                stalls the pipeline until the access completes.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef InstTypeBus
`define InstTypeBus 3:0
`define LB  4'd0
`define LH  4'd1
`define LW  4'd2
`define LBU 4'd3
`define LHU 4'd4
`define SB  4'd5
`define SH  4'd6
`define SW  4'd7
`endif

module mem_stage (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rd_in,
   input  logic [4:0]           rd_addr_in,
   input  logic [31:0]          rd_val_in,
   input  logic [`InstTypeBus]  inst_type_in,
   input  logic                 load_in,
   input  logic                 store_in,
   input  logic [31:0]          mem_addr_in,
   input  logic [31:0]          mem_val_in,
   input  logic                 mem_byte_ack,
   input  logic [7:0]           mem_byte_din,
   output logic                 mem_byte_req,
   output logic                 mem_byte_wr,
   output logic [31:0]          mem_byte_addr,
   output logic [7:0]           mem_byte_dout,
   output logic                 rd_out,
   output logic [4:0]           rd_addr_out,
   output logic [31:0]          rd_val_out,
   output logic                 stallreq_from_mem,
   output logic                 mem_done
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic                 r_is_load;
   logic [`InstTypeBus]  r_type;
   logic [31:0]          r_addr;
   logic [31:0]          r_val;
   logic                 r_rd;
   logic [4:0]           r_rd_addr;
   logic [1:0]           r_idx;
   logic [31:0]          r_buf;
   logic [1:0]           w_last_idx;
   logic [7:0]           w_wr_byte;
   logic [31:0]          w_load_val;

   // Index of the final byte for the latched type; unknown types move a word.
   always_comb begin
      w_last_idx = 2'd3;
      case (r_type)
         `LB, `LBU, `SB: w_last_idx = 2'd0;
         `LH, `LHU, `SH: w_last_idx = 2'd1;
         default:        w_last_idx = 2'd3;
      endcase
   end

   // Select the store byte for the current index and extend the load buffer.
   always_comb begin
      w_wr_byte = r_val[7:0];
      case (r_idx)
         2'd0: w_wr_byte = r_val[7:0];
         2'd1: w_wr_byte = r_val[15:8];
         2'd2: w_wr_byte = r_val[23:16];
         2'd3: w_wr_byte = r_val[31:24];
         default: w_wr_byte = r_val[7:0];
      endcase
      w_load_val = r_buf;
      case (r_type)
         `LB:     w_load_val = {{24{r_buf[7]}}, r_buf[7:0]};
         `LBU:    w_load_val = {24'd0, r_buf[7:0]};
         `LH:     w_load_val = {{16{r_buf[15]}}, r_buf[15:0]};
         `LHU:    w_load_val = {16'd0, r_buf[15:0]};
         default: w_load_val = r_buf;
      endcase
   end

   // State register plus request latches, byte index and load assembly buffer.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state   <= S_IDLE;
         r_is_load <= 1'b0;
         r_type    <= '0;
         r_addr    <= 32'd0;
         r_val     <= 32'd0;
         r_rd      <= 1'b0;
         r_rd_addr <= 5'd0;
         r_idx     <= 2'd0;
         r_buf     <= 32'd0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (load_in || store_in) begin
                  // Load wins when both are asserted.
                  r_is_load <= load_in;
                  r_type    <= inst_type_in;
                  r_addr    <= mem_addr_in;
                  r_val     <= mem_val_in;
                  r_rd      <= rd_in;
                  r_rd_addr <= rd_addr_in;
                  r_idx     <= 2'd0;
                  r_buf     <= 32'd0;
               end
            end
            S_ACCESS: begin
               if (mem_byte_ack) begin
                  if (r_is_load) begin
                     case (r_idx)
                        2'd0: r_buf[7:0]   <= mem_byte_din;
                        2'd1: r_buf[15:8]  <= mem_byte_din;
                        2'd2: r_buf[23:16] <= mem_byte_din;
                        2'd3: r_buf[31:24] <= mem_byte_din;
                        default: r_buf[7:0] <= mem_byte_din;
                     endcase
                  end
                  if (r_idx != w_last_idx) begin
                     r_idx <= r_idx + 2'd1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Next state and all outputs; reset forces every output low.
   always_comb begin
      w_next            = r_state;
      mem_byte_req      = 1'b0;
      mem_byte_wr       = 1'b0;
      mem_byte_addr     = 32'd0;
      mem_byte_dout     = 8'd0;
      rd_out            = 1'b0;
      rd_addr_out       = 5'd0;
      rd_val_out        = 32'd0;
      stallreq_from_mem = 1'b0;
      mem_done          = 1'b0;
      if (rst_in) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (load_in || store_in) begin
                  stallreq_from_mem = 1'b1;
                  w_next            = S_ACCESS;
               end else begin
                  rd_out      = rd_in;
                  rd_addr_out = rd_addr_in;
                  rd_val_out  = rd_val_in;
               end
            end
            S_ACCESS: begin
               stallreq_from_mem = 1'b1;
               mem_byte_req      = 1'b1;
               mem_byte_wr       = ~r_is_load;
               mem_byte_addr     = r_addr + {30'd0, r_idx};
               mem_byte_dout     = w_wr_byte;
               if (mem_byte_ack && (r_idx == w_last_idx)) begin
                  w_next = S_DONE;
               end
            end
            S_DONE: begin
               mem_done    = 1'b1;
               rd_out      = r_rd & r_is_load;
               rd_addr_out = r_rd_addr;
               rd_val_out  = r_is_load ? w_load_val : 32'd0;
               w_next      = S_IDLE;
            end
            default: begin
               w_next = S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none

// ============================================================================
//  Module      : tb_mem_stage
//  Description : Directed self-checking bench for mem_stage.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef InstTypeBus
`define InstTypeBus 3:0
`define LB  4'd0
`define LH  4'd1
`define LW  4'd2
`define LBU 4'd3
`define LHU 4'd4
`define SB  4'd5
`define SH  4'd6
`define SW  4'd7
`endif

module tb_mem_stage;

   logic                clk_in = 1'b0;
   logic                rst_in;
   logic                rd_in;
   logic [4:0]          rd_addr_in;
   logic [31:0]         rd_val_in;
   logic [`InstTypeBus] inst_type_in;
   logic                load_in;
   logic                store_in;
   logic [31:0]         mem_addr_in;
   logic [31:0]         mem_val_in;
   logic                mem_byte_ack;
   logic [7:0]          mem_byte_din;
   logic                mem_byte_req;
   logic                mem_byte_wr;
   logic [31:0]         mem_byte_addr;
   logic [7:0]          mem_byte_dout;
   logic                rd_out;
   logic [4:0]          rd_addr_out;
   logic [31:0]         rd_val_out;
   logic                stallreq_from_mem;
   logic                mem_done;

   int n_checks = 0;
   int n_errors = 0;

   // observations collected by run_op
   int          n_acc, n_req, n_done, unstable, stall_err, lat;
   logic [31:0] tr_addr [4];
   logic [7:0]  tr_dout [4];
   logic        tr_wr   [4];
   logic        req_stall, done_rd_out, done_stall, done_req, idle_stall;
   logic [4:0]  done_rd_addr;
   logic [31:0] done_val;

   mem_stage dut (
      .clk_in(clk_in), .rst_in(rst_in), .rd_in(rd_in), .rd_addr_in(rd_addr_in),
      .rd_val_in(rd_val_in), .inst_type_in(inst_type_in), .load_in(load_in),
      .store_in(store_in), .mem_addr_in(mem_addr_in), .mem_val_in(mem_val_in),
      .mem_byte_ack(mem_byte_ack), .mem_byte_din(mem_byte_din),
      .mem_byte_req(mem_byte_req), .mem_byte_wr(mem_byte_wr),
      .mem_byte_addr(mem_byte_addr), .mem_byte_dout(mem_byte_dout),
      .rd_out(rd_out), .rd_addr_out(rd_addr_out), .rd_val_out(rd_val_out),
      .stallreq_from_mem(stallreq_from_mem), .mem_done(mem_done)
   );

   always #5 clk_in = ~clk_in;

   // Drives one load/store starting at posedge+1 and acks each byte after
   // dly wait cycles; records what the DUT did until the cycle after DONE.
   task automatic run_op(input logic ld, input logic st, input logic [`InstTypeBus] typ,
                         input logic [31:0] addr, input logic [31:0] val,
                         input int dly, input logic [31:0] din_word);
      int   wcnt;
      int   cyc;
      logic acked;
      logic was_req;
      logic stop;
      n_acc = 0; n_req = 0; n_done = 0; unstable = 0; stall_err = 0; lat = -1;
      wcnt = 0; stop = 1'b0; idle_stall = 1'bx;
      done_rd_out = 1'bx; done_stall = 1'bx; done_req = 1'bx;
      done_rd_addr = 'x; done_val = 'x;
      for (int i = 0; i < 4; i++) begin
         tr_addr[i] = 'x; tr_dout[i] = 'x; tr_wr[i] = 1'bx;
      end
      load_in = ld; store_in = st; inst_type_in = typ;
      mem_addr_in = addr; mem_val_in = val;
      rd_in = 1'b1; rd_addr_in = 5'd9; rd_val_in = 32'h5A5A_5A5A;
      #1;
      req_stall = stallreq_from_mem;
      @(posedge clk_in); #1;
      load_in = 1'b0; store_in = 1'b0;
      cyc = 1;
      while (!stop && cyc < 64) begin
         #1;
         acked = 1'b0;
         was_req = mem_byte_req;
         if (mem_byte_req) begin
            n_req++;
            if (!stallreq_from_mem) stall_err++;
            if (n_acc < 4) begin
               if (wcnt == 0) begin
                  tr_addr[n_acc] = mem_byte_addr;
                  tr_dout[n_acc] = mem_byte_dout;
                  tr_wr[n_acc]   = mem_byte_wr;
               end else if (mem_byte_addr !== tr_addr[n_acc] ||
                            mem_byte_dout !== tr_dout[n_acc] ||
                            mem_byte_wr !== tr_wr[n_acc]) begin
                  unstable++;
               end
               if (wcnt == dly) begin
                  mem_byte_ack = 1'b1;
                  mem_byte_din = din_word[8*n_acc +: 8];
                  acked = 1'b1;
               end
            end
         end
         if (mem_done) begin
            n_done++;
            done_rd_out = rd_out; done_rd_addr = rd_addr_out; done_val = rd_val_out;
            done_stall = stallreq_from_mem; done_req = mem_byte_req;
         end else if (n_done > 0) begin
            stop = 1'b1;
            lat = cyc;
            idle_stall = stallreq_from_mem;
         end
         if (!stop) begin
            @(posedge clk_in); #1;
            mem_byte_ack = 1'b0;
            if (acked) begin
               n_acc++;
               wcnt = 0;
            end else if (was_req) begin
               wcnt++;
            end
            cyc++;
         end
      end
      if (!stop) begin
         n_checks++; n_errors++;
         $display("FAIL run_op_timeout got no completion expected completion within 64 cycles");
      end
      rd_in = 1'b0;
   endtask

   task automatic test_reset();
      rst_in = 1'b1; load_in = 1'b1; store_in = 1'b1; rd_in = 1'b1;
      rd_addr_in = 5'd3; rd_val_in = 32'hFFFF_FFFF; inst_type_in = `LW;
      @(posedge clk_in); #1;
      n_checks++; if (mem_byte_req !== 1'b0) begin n_errors++; $display("FAIL reset_req got %0b expected 0", mem_byte_req); end
      n_checks++; if (mem_byte_wr !== 1'b0) begin n_errors++; $display("FAIL reset_wr got %0b expected 0", mem_byte_wr); end
      n_checks++; if (stallreq_from_mem !== 1'b0) begin n_errors++; $display("FAIL reset_stall got %0b expected 0", stallreq_from_mem); end
      n_checks++; if (mem_done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %0b expected 0", mem_done); end
      n_checks++; if (rd_out !== 1'b0) begin n_errors++; $display("FAIL reset_rd_out got %0b expected 0", rd_out); end
      n_checks++; if (rd_addr_out !== 5'd0) begin n_errors++; $display("FAIL reset_rd_addr got %0h expected 0", rd_addr_out); end
      n_checks++; if (rd_val_out !== 32'd0) begin n_errors++; $display("FAIL reset_rd_val got %0h expected 0", rd_val_out); end
      @(posedge clk_in); #1;
      rst_in = 1'b0; load_in = 1'b0; store_in = 1'b0; rd_in = 1'b0;
      @(posedge clk_in); #1;
      n_checks++; if (mem_byte_req !== 1'b0) begin n_errors++; $display("FAIL post_reset_req got %0b expected 0", mem_byte_req); end
   endtask

   task automatic test_passthrough();
      rd_in = 1'b1; rd_addr_in = 5'd5; rd_val_in = 32'h0000_1234;
      #1;
      n_checks++; if (rd_out !== 1'b1) begin n_errors++; $display("FAIL pass_rd_out got %0b expected 1", rd_out); end
      n_checks++; if (rd_addr_out !== 5'd5) begin n_errors++; $display("FAIL pass_rd_addr got %0h expected 5", rd_addr_out); end
      n_checks++; if (rd_val_out !== 32'h0000_1234) begin n_errors++; $display("FAIL pass_rd_val got %0h expected 1234", rd_val_out); end
      n_checks++; if (stallreq_from_mem !== 1'b0) begin n_errors++; $display("FAIL pass_stall got %0b expected 0", stallreq_from_mem); end
      rd_in = 1'b0; rd_addr_in = 5'd31; rd_val_in = 32'hFFFF_FFFF;
      #1;
      n_checks++; if (rd_out !== 1'b0 || rd_addr_out !== 5'd31 || rd_val_out !== 32'hFFFF_FFFF) begin
         n_errors++; $display("FAIL pass2 got %0b/%0h/%0h expected 0/1f/ffffffff", rd_out, rd_addr_out, rd_val_out); end
      @(posedge clk_in); #1;
   endtask

   task automatic test_lb();
      run_op(1'b1, 1'b0, `LB, 32'h0000_0100, 32'd0, 0, 32'h0000_0080);
      n_checks++; if (req_stall !== 1'b1) begin n_errors++; $display("FAIL lb_req_stall got %0b expected 1", req_stall); end
      n_checks++; if (n_req !== 1) begin n_errors++; $display("FAIL lb_req_cycles got %0d expected 1", n_req); end
      n_checks++; if (tr_addr[0] !== 32'h100 || tr_wr[0] !== 1'b0) begin n_errors++; $display("FAIL lb_addr got %0h wr %0b expected 100 wr 0", tr_addr[0], tr_wr[0]); end
      n_checks++; if (n_done !== 1) begin n_errors++; $display("FAIL lb_done_pulses got %0d expected 1", n_done); end
      n_checks++; if (done_val !== 32'hFFFF_FF80) begin n_errors++; $display("FAIL lb_value got %0h expected ffffff80", done_val); end
      n_checks++; if (done_rd_out !== 1'b1 || done_rd_addr !== 5'd9) begin n_errors++; $display("FAIL lb_rd got %0b/%0h expected 1/9", done_rd_out, done_rd_addr); end
      n_checks++; if (done_stall !== 1'b0 || done_req !== 1'b0) begin n_errors++; $display("FAIL lb_done_stall_req got %0b/%0b expected 0/0", done_stall, done_req); end
      n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL lb_latency got %0d expected 3", lat); end
      n_checks++; if (idle_stall !== 1'b0) begin n_errors++; $display("FAIL lb_no_retrigger got %0b expected 0", idle_stall); end
      run_op(1'b1, 1'b0, `LBU, 32'h0000_0100, 32'd0, 0, 32'h0000_0080);
      n_checks++; if (done_val !== 32'h0000_0080) begin n_errors++; $display("FAIL lbu_value got %0h expected 80", done_val); end
   endtask

   task automatic test_halfwords();
      run_op(1'b1, 1'b0, `LH, 32'h0000_0040, 32'd0, 0, 32'h0000_8001);
      n_checks++; if (done_val !== 32'hFFFF_8001 || n_acc !== 2) begin n_errors++; $display("FAIL lh_value got %0h bytes %0d expected ffff8001 bytes 2", done_val, n_acc); end
      n_checks++; if (lat !== 4) begin n_errors++; $display("FAIL lh_latency got %0d expected 4", lat); end
      run_op(1'b1, 1'b0, `LHU, 32'h0000_0040, 32'd0, 0, 32'h0000_8001);
      n_checks++; if (done_val !== 32'h0000_8001) begin n_errors++; $display("FAIL lhu_value got %0h expected 8001", done_val); end
      run_op(1'b0, 1'b1, `SH, 32'h0000_0060, 32'h1234_ABCD, 1, 32'd0);
      n_checks++; if (n_acc !== 2 || tr_dout[0] !== 8'hCD || tr_dout[1] !== 8'hAB || tr_addr[1] !== 32'h61) begin
         n_errors++; $display("FAIL sh_bytes got n=%0d %0h %0h @%0h expected 2 cd ab @61", n_acc, tr_dout[0], tr_dout[1], tr_addr[1]); end
   endtask

   task automatic test_sw_delayed();
      logic [7:0] exp_b [4];
      exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
      run_op(1'b0, 1'b1, `SW, 32'h0000_2000, 32'hDEAD_BEEF, 2, 32'd0);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (tr_addr[i] !== 32'h2000 + i || tr_dout[i] !== exp_b[i] || tr_wr[i] !== 1'b1) begin
            n_errors++; $display("FAIL sw_byte%0d got %0h=%0h wr %0b expected %0h=%0h wr 1", i, tr_addr[i], tr_dout[i], tr_wr[i], 32'h2000 + i, exp_b[i]);
         end
      end
      n_checks++; if (unstable !== 0 || stall_err !== 0) begin n_errors++; $display("FAIL sw_stable got %0d unstable %0d stall errs expected 0 0", unstable, stall_err); end
      n_checks++; if (n_req !== 12) begin n_errors++; $display("FAIL sw_req_cycles got %0d expected 12", n_req); end
      n_checks++; if (done_rd_out !== 1'b0 || done_val !== 32'd0) begin n_errors++; $display("FAIL sw_done_rd got %0b/%0h expected 0/0", done_rd_out, done_val); end
      n_checks++; if (n_done !== 1) begin n_errors++; $display("FAIL sw_done_pulses got %0d expected 1", n_done); end
   endtask

   task automatic test_lw_wrap();
      logic [31:0] exp_a [4];
      exp_a[0] = 32'hFFFF_FFFE; exp_a[1] = 32'hFFFF_FFFF; exp_a[2] = 32'h0000_0000; exp_a[3] = 32'h0000_0001;
      run_op(1'b1, 1'b0, `LW, 32'hFFFF_FFFE, 32'd0, 0, 32'h4433_2211);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (tr_addr[i] !== exp_a[i]) begin n_errors++; $display("FAIL lw_addr%0d got %0h expected %0h", i, tr_addr[i], exp_a[i]); end
      end
      n_checks++; if (done_val !== 32'h4433_2211) begin n_errors++; $display("FAIL lw_value got %0h expected 44332211", done_val); end
      n_checks++; if (lat !== 6) begin n_errors++; $display("FAIL lw_latency got %0d expected 6", lat); end
   endtask

   task automatic test_reset_mid();
      rd_in = 1'b0; load_in = 1'b1; store_in = 1'b0; inst_type_in = `LH;
      mem_addr_in = 32'h0000_0300;
      @(posedge clk_in); #1;
      load_in = 1'b0;
      #1; mem_byte_ack = 1'b1; mem_byte_din = 8'h12;
      @(posedge clk_in); #1;
      mem_byte_ack = 1'b0;
      n_checks++; if (mem_byte_req !== 1'b1 || mem_byte_addr !== 32'h301) begin n_errors++; $display("FAIL rstmid_second_byte got req %0b @%0h expected 1 @301", mem_byte_req, mem_byte_addr); end
      rst_in = 1'b1;
      #1;
      n_checks++; if (mem_byte_req !== 1'b0 || stallreq_from_mem !== 1'b0) begin n_errors++; $display("FAIL rstmid_during got req %0b stall %0b expected 0 0", mem_byte_req, stallreq_from_mem); end
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      #1;
      n_checks++; if (mem_byte_req !== 1'b0 || stallreq_from_mem !== 1'b0 || mem_done !== 1'b0) begin
         n_errors++; $display("FAIL rstmid_after got req %0b stall %0b done %0b expected 0 0 0", mem_byte_req, stallreq_from_mem, mem_done); end
      @(posedge clk_in); #1;
      n_checks++; if (mem_done !== 1'b0 || mem_byte_req !== 1'b0) begin n_errors++; $display("FAIL rstmid_idle got done %0b req %0b expected 0 0", mem_done, mem_byte_req); end
      run_op(1'b1, 1'b0, `LH, 32'h0000_0400, 32'd0, 0, 32'h0000_1234);
      n_checks++; if (done_val !== 32'h0000_1234 || n_done !== 1 || tr_addr[0] !== 32'h400) begin
         n_errors++; $display("FAIL rstmid_fresh_lh got %0h done %0d @%0h expected 1234 done 1 @400", done_val, n_done, tr_addr[0]); end
   endtask

   task automatic test_priority();
      mem_byte_ack = 1'b1; mem_byte_din = 8'hAA;
      #1;
      n_checks++; if (mem_byte_req !== 1'b0) begin n_errors++; $display("FAIL spurious_req got %0b expected 0", mem_byte_req); end
      @(posedge clk_in); #1;
      mem_byte_ack = 1'b0;
      n_checks++; if (stallreq_from_mem !== 1'b0 || mem_done !== 1'b0) begin n_errors++; $display("FAIL spurious_state got stall %0b done %0b expected 0 0", stallreq_from_mem, mem_done); end
      run_op(1'b1, 1'b1, `LW, 32'h0000_0500, 32'hFFFF_FFFF, 0, 32'hCAFE_F00D);
      n_checks++; if (tr_wr[0] !== 1'b0 || tr_wr[1] !== 1'b0 || tr_wr[2] !== 1'b0 || tr_wr[3] !== 1'b0) begin
         n_errors++; $display("FAIL prio_wr got %0b%0b%0b%0b expected 0000", tr_wr[0], tr_wr[1], tr_wr[2], tr_wr[3]); end
      n_checks++; if (done_val !== 32'hCAFE_F00D || done_rd_out !== 1'b1) begin n_errors++; $display("FAIL prio_value got %0h rd %0b expected cafef00d rd 1", done_val, done_rd_out); end
      run_op(1'b1, 1'b0, 4'hF, 32'h0000_0600, 32'd0, 0, 32'h8765_4321);
      n_checks++; if (n_acc !== 4 || done_val !== 32'h8765_4321) begin n_errors++; $display("FAIL other_type got bytes %0d val %0h expected 4 87654321", n_acc, done_val); end
   endtask

   initial begin
      rst_in = 1'b1; rd_in = 1'b0; rd_addr_in = 5'd0; rd_val_in = 32'd0;
      inst_type_in = `LB; load_in = 1'b0; store_in = 1'b0;
      mem_addr_in = 32'd0; mem_val_in = 32'd0; mem_byte_ack = 1'b0; mem_byte_din = 8'd0;
      repeat (2) @(posedge clk_in);
      #1;
      test_reset();
      test_passthrough();
      test_lb();
      test_halfwords();
      test_sw_delayed();
      test_lw_wrap();
      test_reset_mid();
      test_priority();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
